id_ex_hazard_reg: RTL

ID/EX pipeline register with integrated load-use hazard detection, branch flush and memory-hold freezing for the five-stage RISC-V core. It captures decoded operands and control from ID and presents the registered `id_ex_*` fields consumed by the EX-stage forwarding unit and ALU operand muxes. On a load-use hazard it inserts one bubble and stalls PC and IF/ID. It also keeps saturating stall and flush event counters for performance reporting.

---
 rtl/id_ex_hazard_reg_pkg.sv | 47 ++++
 rtl/id_ex_hazard_reg_load_use_detect.sv | 23 ++
 rtl/id_ex_hazard_reg.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: immediate-slot code, ALU op
// encodings, per-edge register action and the control bundle carried into EX.
package id_ex_hazard_reg_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [4:0] IMM_RS2_SLOT = 5'b00001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_FLUSH   = 2'd2,
        ACT_HOLD    = 2'd3
    } reg_action_e;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // A memory hold freezes EX as well, so it outranks both flush and bubble.
    function automatic reg_action_e select_action(input logic mem_hold,
                                                  input logic branch_taken,
                                                  input logic load_use);
        if (mem_hold)          return ACT_HOLD;
        else if (branch_taken) return ACT_FLUSH;
        else if (load_use)     return ACT_BUBBLE;
        else                   return ACT_CAPTURE;
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the
// instruction in ID. Kept standalone so a branch-in-ID comparator can reuse it.
module load_use_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 & (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 & (ex_rd == id_rs2);
    assign load_use  = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid
                     & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, memory-hold
// freeze and saturating stall/flush event counters.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_RegWrite,
    input  logic             id_MemtoReg,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic [3:0]       id_ALUOp,
    input  logic [XLEN-1:0]  id_Imm,
    input  logic [4:0]       id_Imm_extend,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic             ex_branch_taken,
    input  logic             mem_hold,
    output logic             id_ex_valid,
    output logic [4:0]       id_ex_rs1,
    output logic [4:0]       id_ex_rs2,
    output logic [4:0]       id_ex_rd,
    output logic             id_ex_RegWrite,
    output logic             id_ex_MemtoReg,
    output logic             id_ex_MemRead,
    output logic             id_ex_MemWrite,
    output logic [3:0]       id_ex_ALUOp,
    output logic [XLEN-1:0]  id_ex_Imm,
    output logic [4:0]       id_ex_Imm_extend,
    output logic [XLEN-1:0]  id_ex_pc,
    output logic [XLEN-1:0]  id_ex_rdata1,
    output logic [XLEN-1:0]  id_ex_rdata2,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_t             ctrl_q,   ctrl_d;
    logic [4:0]        rs1_q,    rs1_d;
    logic [4:0]        rs2_q,    rs2_d;
    logic [4:0]        rd_q,     rd_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [XLEN-1:0]   imm_q,    imm_d;
    logic [4:0]        imm_ext_q, imm_ext_d;
    logic [XLEN-1:0]   pc_q,     pc_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [XLEN-1:0]   rdata2_q, rdata2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;
    reg_action_e       action;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    load_use_detect u_load_use_detect (
        .ex_valid    (ctrl_q.valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    // A taken branch kills the ID instruction anyway, so it suppresses the stall.
    assign stall  = mem_hold | (load_use & ~ex_branch_taken);
    assign action = select_action(mem_hold, ex_branch_taken, load_use);

    always_comb begin
        ctrl_d      = ctrl_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        alu_op_d    = alu_op_q;
        imm_d       = imm_q;
        imm_ext_d   = imm_ext_q;
        pc_d        = pc_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (action)
            ACT_HOLD: begin
            end
            ACT_FLUSH: begin
                ctrl_d      = '0;
                rd_d        = 5'd0;
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
            ACT_BUBBLE: begin
                ctrl_d      = '0;
                rd_d        = 5'd0;
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            default: begin
                ctrl_d.valid      = id_valid;
                ctrl_d.reg_write  = id_valid & id_RegWrite;
                ctrl_d.mem_to_reg = id_valid & id_MemtoReg;
                ctrl_d.mem_read   = id_valid & id_MemRead;
                ctrl_d.mem_write  = id_valid & id_MemWrite;
                rs1_d     = id_rs1;
                rs2_d     = id_rs2;
                rd_d      = id_rd;
                alu_op_d  = id_ALUOp;
                imm_d     = id_Imm;
                imm_ext_d = id_Imm_extend;
                pc_d      = id_pc;
                rdata1_d  = id_rdata1;
                rdata2_d  = id_rdata2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= '0;
            imm_q       <= '0;
            imm_ext_q   <= '0;
            pc_q        <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            imm_q       <= imm_d;
            imm_ext_q   <= imm_ext_d;
            pc_q        <= pc_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_ex_valid      = ctrl_q.valid;
    assign id_ex_RegWrite   = ctrl_q.reg_write;
    assign id_ex_MemtoReg   = ctrl_q.mem_to_reg;
    assign id_ex_MemRead    = ctrl_q.mem_read;
    assign id_ex_MemWrite   = ctrl_q.mem_write;
    assign id_ex_rs1        = rs1_q;
    assign id_ex_rs2        = rs2_q;
    assign id_ex_rd         = rd_q;
    assign id_ex_ALUOp      = alu_op_q;
    assign id_ex_Imm        = imm_q;
    assign id_ex_Imm_extend = imm_ext_q;
    assign id_ex_pc         = pc_q;
    assign id_ex_rdata1     = rdata1_q;
    assign id_ex_rdata2     = rdata2_q;
    assign stall_count      = stall_cnt_q;
    assign flush_count      = flush_cnt_q;

endmodule
